// File: rtl/uart_link.sv
// uart_link: 8N1 UART transceiver, dedicated TX bit timer, 16x oversampled RX
module uart_link #(
  parameter int CLK_HZ = 50000000,
  parameter int BAUD = 9600,
  parameter int DIV = CLK_HZ / (BAUD * 16)
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] TX_DATA,
  input  logic       TX_EN,
  output logic       TX_STATUS,
  output logic [7:0] RX_DATA,
  output logic       RX_EFF,
  input  logic       RX_READ,
  output logic       RX_OVR,
  output logic       RX_FERR,
  input  logic       serial_rx,
  output logic       serial_tx
);
  localparam int BP = 16 * DIV;
  localparam int BW = $clog2(BP);
  localparam int DW = DIV > 1 ? $clog2(DIV) : 1;

  typedef enum logic [1:0] {T_IDLE, T_START, T_DATA, T_STOP} tx_st_t;
  typedef enum logic [2:0] {R_IDLE, R_START, R_DATA, R_STOP, R_WAIT} rx_st_t;

  tx_st_t tx_st, tx_st_n;
  logic [BW-1:0] tx_cnt;
  logic [2:0] tx_bit;
  logic [7:0] tx_sr, tx_sr_n;
  logic tx_acc, bp_end;

  assign TX_STATUS = tx_st == T_IDLE;
  assign tx_acc = TX_EN && TX_STATUS;
  assign bp_end = tx_cnt == BW'(BP - 1);

  always_comb begin
    tx_st_n = tx_acc ? T_START
      : (tx_st == T_IDLE || !bp_end) ? tx_st
      : tx_st == T_START ? T_DATA
      : (tx_st == T_DATA && tx_bit != 3'd7) ? T_DATA
      : tx_st == T_DATA ? T_STOP : T_IDLE;
    tx_sr_n = tx_acc ? TX_DATA : (tx_st == T_DATA && bp_end) ? {1'b0, tx_sr[7:1]} : tx_sr;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      tx_st <= T_IDLE;
      tx_cnt <= '0;
      tx_bit <= '0;
      tx_sr <= '0;
      serial_tx <= 1'b1;
    end else begin
      tx_st <= tx_st_n;
      tx_cnt <= (tx_st == T_IDLE || bp_end) ? '0 : tx_cnt + 1'b1;
      tx_bit <= (tx_st == T_DATA && bp_end) ? tx_bit + 1'b1 : tx_bit;
      tx_sr <= tx_sr_n;
      serial_tx <= tx_st_n == T_START ? 1'b0 : tx_st_n == T_DATA ? tx_sr_n[0] : 1'b1;
    end
  end

  rx_st_t rx_st, rx_st_n;
  logic rx_s1, rx_s2, rx_prev;
  logic [DW-1:0] div_cnt;
  logic [3:0] tk_cnt;
  logic [2:0] rx_bit;
  logic [7:0] rx_sr;
  logic fall, tick, smp, done, ferr;

  assign fall = rx_prev && !rx_s2;
  assign tick = div_cnt == DW'(DIV - 1);
  assign smp = tick && tk_cnt == (rx_st == R_START ? 4'd7 : 4'd15);
  assign done = rx_st == R_STOP && smp && rx_s2;
  assign ferr = rx_st == R_STOP && smp && !rx_s2;

  always_comb begin
    rx_st_n = rx_st == R_IDLE ? (fall ? R_START : R_IDLE)
      : rx_st == R_WAIT ? (rx_s2 ? R_IDLE : R_WAIT)
      : !smp ? rx_st
      : rx_st == R_START ? (rx_s2 ? R_IDLE : R_DATA)
      : rx_st == R_DATA ? (rx_bit == 3'd7 ? R_STOP : R_DATA)
      : rx_s2 ? R_IDLE : R_WAIT;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      rx_s1 <= 1'b1;
      rx_s2 <= 1'b1;
      rx_prev <= 1'b1;
      rx_st <= R_IDLE;
      div_cnt <= '0;
      tk_cnt <= '0;
      rx_bit <= '0;
      rx_sr <= '0;
      RX_DATA <= '0;
      RX_EFF <= 1'b0;
      RX_OVR <= 1'b0;
      RX_FERR <= 1'b0;
    end else begin
      rx_s1 <= serial_rx;
      rx_s2 <= rx_s1;
      rx_prev <= rx_s2;
      rx_st <= rx_st_n;
      div_cnt <= ((rx_st == R_IDLE && fall) || tick) ? '0 : div_cnt + 1'b1;
      tk_cnt <= (rx_st == R_IDLE || (rx_st == R_START && smp)) ? '0 : tick ? tk_cnt + 1'b1 : tk_cnt;
      rx_bit <= (rx_st == R_DATA && smp) ? rx_bit + 1'b1 : rx_bit;
      rx_sr <= (rx_st == R_DATA && smp) ? {rx_s2, rx_sr[7:1]} : rx_sr;
      RX_DATA <= done ? rx_sr : RX_DATA;
      RX_EFF <= done | (RX_EFF & ~RX_READ);
      RX_OVR <= done ? (RX_EFF & ~RX_READ) : (RX_OVR & ~(RX_READ & RX_EFF));
      RX_FERR <= ferr;
    end
  end
endmodule
